// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared constants and sizing helpers for the switch/button conditioner
package input_conditioner_pkg;

    localparam logic SW_IDLE    = 1'b0;
    localparam logic BTN_N_IDLE = 1'b1;

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int cnt_w(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: two-flop synchroniser, tick-qualified stable level and registered edge pulses for one pad
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_TICKS = 10,
    parameter logic IDLE           = 1'b0,
    parameter logic INVERT         = 1'b0
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_w(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt, cnt_d;
    logic          sync, accept, level_d;

    assign sync = sync_q[1] ^ INVERT;

    // any cycle where the input agrees with the stable level restarts qualification
    always_comb begin
        accept  = sync != level && tick && cnt == LAST;
        cnt_d   = (sync == level || accept) ? '0 : tick ? cnt + 1'b1 : cnt;
        level_d = accept ? sync : level;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync_q <= {2{IDLE}};
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            cnt    <= cnt_d;
            level  <= level_d;
            rise   <= level_d & ~level;
            fall   <= ~level_d & level;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounced switches/buttons with press/release pulses; INPUT_CONDITIONER_EVENT_LATCH_EN adds sticky press flags
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_SW         = 18,
    parameter int NUM_BTN        = 4,
    parameter int CLK_HZ         = 50000000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_BTN-1:0] btn_raw_n,
    output logic [NUM_SW-1:0]  sw_export,
    output logic [NUM_BTN-1:0] btn_export,
    output logic [NUM_BTN-1:0] btn_press,
`ifdef INPUT_CONDITIONER_EVENT_LATCH_EN
    input  logic [NUM_BTN-1:0] btn_evt_clr,
    output logic [NUM_BTN-1:0] btn_evt,
`endif
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int PW       = $clog2(TICK_DIV);
    localparam int NB       = NUM_SW + NUM_BTN;

    logic [PW-1:0]     pcnt;
    logic              tick;
    logic [NB-1:0]     raw_all, level_all, rise_all, fall_all;
    logic [NUM_SW-1:0] sw_rise_unused, sw_fall_unused;

    assign tick = pcnt == PW'(TICK_DIV - 1);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            pcnt <= '0;
        else
            pcnt <= tick ? '0 : pcnt + 1'b1;
    end

    assign raw_all = {btn_raw_n, sw_raw};

    // switches occupy the low bits, active-low buttons the high bits
    for (genvar i = 0; i < NB; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .IDLE          (i < NUM_SW ? SW_IDLE : BTN_N_IDLE),
            .INVERT        (i >= NUM_SW)
        ) u_bit (
            .clk_clk      (clk_clk),
            .reset_reset_n(reset_reset_n),
            .tick         (tick),
            .raw          (raw_all[i]),
            .level        (level_all[i]),
            .rise         (rise_all[i]),
            .fall         (fall_all[i])
        );
    end

    assign sw_export      = level_all[NUM_SW-1:0];
    assign btn_export     = level_all[NUM_SW +: NUM_BTN];
    assign btn_press      = rise_all[NUM_SW +: NUM_BTN];
    assign btn_release    = fall_all[NUM_SW +: NUM_BTN];
    assign sw_rise_unused = rise_all[NUM_SW-1:0];
    assign sw_fall_unused = fall_all[NUM_SW-1:0];

`ifdef INPUT_CONDITIONER_EVENT_LATCH_EN
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            btn_evt <= '0;
        else
            btn_evt <= btn_press | (btn_evt & ~btn_evt_clr);
    end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of debounce latency, glitch rejection, reset abort and event latch
module tb_input_conditioner;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [17:0] sw_raw = '0;
    logic [3:0]  btn_raw_n = '1;
    logic [17:0] sw_export;
    logic [3:0]  btn_export, btn_press, btn_release;
`ifdef INPUT_CONDITIONER_EVENT_LATCH_EN
    logic [3:0]  btn_evt_clr = '0;
    logic [3:0]  btn_evt;
`endif

    int checks = 0;
    int fails = 0;

    always #5 clk_clk = ~clk_clk;

    input_conditioner #(
        .NUM_SW(18), .NUM_BTN(4), .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_TICKS(4)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .sw_raw       (sw_raw),
        .btn_raw_n    (btn_raw_n),
        .sw_export    (sw_export),
        .btn_export   (btn_export),
        .btn_press    (btn_press),
`ifdef INPUT_CONDITIONER_EVENT_LATCH_EN
        .btn_evt_clr  (btn_evt_clr),
        .btn_evt      (btn_evt),
`endif
        .btn_release  (btn_release)
    );

    task automatic at_edge;
        @(posedge clk_clk);
        #1;
    endtask

    task automatic wait_btn(input int i, input logic v, output int lat);
        lat = -1;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
            if (btn_export[i] === v) lat = n;
        end
    endtask

    task automatic test_reset;
        reset_reset_n = 1'b0;
        repeat (3) at_edge;
        @(negedge clk_clk);
        checks++; if (sw_export !== '0) begin fails++; $display("FAIL reset_sw: got %h expected 0", sw_export); end
        checks++; if (btn_export !== '0) begin fails++; $display("FAIL reset_btn: got %h expected 0", btn_export); end
        checks++; if (btn_press !== '0) begin fails++; $display("FAIL reset_press: got %h expected 0", btn_press); end
        checks++; if (btn_release !== '0) begin fails++; $display("FAIL reset_release: got %h expected 0", btn_release); end
        at_edge;
        reset_reset_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_clk);
            checks++;
            if ({sw_export, btn_export, btn_press, btn_release} !== '0) begin
                fails++;
                $display("FAIL idle_quiet: cycle %0d got %h expected 0", n, {sw_export, btn_export, btn_press, btn_release});
            end
        end
    endtask

    task automatic test_press_release;
        int lat;
        at_edge;
        btn_raw_n[0] = 1'b0;
        wait_btn(0, 1'b1, lat);
        checks++; if (lat < 33 || lat > 43) begin fails++; $display("FAIL press_latency: got %0d expected 33..43", lat); end
        checks++; if (btn_press !== 4'b0001) begin fails++; $display("FAIL press_pulse: got %b expected 0001", btn_press); end
        checks++; if ({sw_export, btn_export, btn_release} !== {18'h0, 4'b0001, 4'b0000}) begin
            fails++; $display("FAIL press_others: got %h/%b/%b expected 0/0001/0000", sw_export, btn_export, btn_release);
        end
        @(negedge clk_clk);
        checks++; if (btn_press !== 4'b0000) begin fails++; $display("FAIL press_one_cycle: got %b expected 0000", btn_press); end
        at_edge;
        btn_raw_n[0] = 1'b1;
        wait_btn(0, 1'b0, lat);
        checks++; if (lat < 33 || lat > 43) begin fails++; $display("FAIL release_latency: got %0d expected 33..43", lat); end
        checks++; if ({btn_release, btn_press} !== {4'b0001, 4'b0000}) begin
            fails++; $display("FAIL release_pulse: got rel %b press %b expected 0001/0000", btn_release, btn_press);
        end
        @(negedge clk_clk);
        checks++; if (btn_release !== 4'b0000) begin fails++; $display("FAIL release_one_cycle: got %b expected 0000", btn_release); end
    endtask

    task automatic test_bounce;
        int lat;
        int bad;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            at_edge;
            btn_raw_n[1] = i[0];
            repeat (6) begin
                @(negedge clk_clk);
                if (btn_export[1] !== 1'b0) bad++;
                @(posedge clk_clk);
            end
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL bounce_reject: got %0d cycles high expected 0", bad); end
        at_edge;
        btn_raw_n[1] = 1'b0;
        wait_btn(1, 1'b1, lat);
        checks++; if (lat < 33 || lat > 43) begin fails++; $display("FAIL bounce_latency: got %0d expected 33..43", lat); end
        checks++; if (btn_press !== 4'b0010) begin fails++; $display("FAIL bounce_pulse: got %b expected 0010", btn_press); end
    endtask

    task automatic test_switches;
        int lat;
        int split;
        lat = -1;
        split = 0;
        at_edge;
        sw_raw = 18'h2A5A5;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
            if (sw_export !== 18'h0 && sw_export !== 18'h2A5A5) split++;
            if (sw_export === 18'h2A5A5) lat = n;
        end
        checks++; if (lat < 1 || lat > 43) begin fails++; $display("FAIL sw_latency: got %0d expected 1..43", lat); end
        checks++; if (split != 0) begin fails++; $display("FAIL sw_same_cycle: got %0d partial cycles expected 0", split); end
        checks++; if (btn_export !== 4'b0010) begin fails++; $display("FAIL sw_btn_untouched: got %b expected 0010", btn_export); end
    endtask

    task automatic test_reset_abort;
        int lat;
        int bad;
        bad = 0;
        reset_reset_n = 1'b0;
        btn_raw_n[2] = 1'b0;
        repeat (2) at_edge;
        reset_reset_n = 1'b1;
        // ticks land 9, 19, 29 edges after release, so the counter sits at 2 here
        repeat (23) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
            if (btn_export[2] !== 1'b0 || btn_press[2] !== 1'b0) bad++;
        end
        #1;
        reset_reset_n = 1'b0;
        repeat (2) at_edge;
        reset_reset_n = 1'b1;
        checks++; if (bad != 0) begin fails++; $display("FAIL abort_pre: got %0d early cycles expected 0", bad); end
        checks++; if ({btn_export[2], btn_press[2]} !== 2'b00) begin
            fails++; $display("FAIL abort_cleared: got %b expected 00", {btn_export[2], btn_press[2]});
        end
        wait_btn(2, 1'b1, lat);
        checks++; if (lat < 33 || lat > 43) begin fails++; $display("FAIL abort_fresh_latency: got %0d expected 33..43", lat); end
        checks++; if (btn_press[2] !== 1'b1) begin fails++; $display("FAIL abort_pulse: got %b expected 1", btn_press[2]); end
    endtask

`ifdef INPUT_CONDITIONER_EVENT_LATCH_EN
    task automatic test_event_latch;
        int lat;
        int seen;
        at_edge;
        btn_raw_n[3] = 1'b0;
        wait_btn(3, 1'b1, lat);
        repeat (2) @(negedge clk_clk);
        checks++; if (btn_evt[3] !== 1'b1) begin fails++; $display("FAIL evt_set: got %b expected 1", btn_evt[3]); end
        at_edge;
        btn_raw_n[3] = 1'b1;
        wait_btn(3, 1'b0, lat);
        at_edge;
        btn_raw_n[3] = 1'b0;
        seen = 0;
        for (int n = 0; n < 60 && seen == 0; n++) begin
            @(negedge clk_clk);
            if (btn_press[3] === 1'b1) seen = 1;
        end
        checks++; if (seen != 1) begin fails++; $display("FAIL evt_second_press: got %0d expected 1", seen); end
        btn_evt_clr[3] = 1'b1;
        at_edge;
        btn_evt_clr[3] = 1'b0;
        @(negedge clk_clk);
        checks++; if (btn_evt[3] !== 1'b1) begin fails++; $display("FAIL evt_set_wins: got %b expected 1", btn_evt[3]); end
        repeat (3) at_edge;
        btn_evt_clr[3] = 1'b1;
        at_edge;
        btn_evt_clr[3] = 1'b0;
        @(negedge clk_clk);
        checks++; if (btn_evt[3] !== 1'b0) begin fails++; $display("FAIL evt_clear: got %b expected 0", btn_evt[3]); end
    endtask
`endif

    initial begin
        test_reset;
        test_press_release;
        test_bounce;
        test_switches;
        test_reset_abort;
`ifdef INPUT_CONDITIONER_EVENT_LATCH_EN
        test_event_latch;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
